pipe_flow_ctrl: RTL and testbench

//  Pipeline flow controller; consumes hazard/redirect requests from the hazard/forwarding manager and memory ready flags.

---
 rtl/pipe_flow_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_flow_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_flow_ctrl
//
// Flow controller for a five-stage pipeline (FETCH, DE, EXE, ACC, WB).
// It takes load-use stall and branch redirect requests from the hazard manager
// and the ready flags of both memories. From these it produces:
//   - per-stage register enables
//   - a bubble into DE->EXE
//   - a squash of FETCH->DE and DE->EXE when a redirect is applied
// A redirect that arrives while a data access is outstanding is held as
// pending and applied on release. A watchdog flags data waits that run too
// long. Two saturating performance counters record stalled and redirected
// cycles.
//
// Parameters
//   NOP_INSTR  bubble instruction. The datapath loads it on de_bubble and the
//              flushes. It is kept here so the pipeline has one source for it.
//   MAX_WAIT   number of dmem wait cycles tolerated before timeout_err is set
//   CNT_W      width of the performance counters
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   stall_req                load-use stall request
//   redirect_req/_pc         taken branch/jump resolved in EXE, and its target
//   imem_ready, dmem_ready   memory ready flags
//   pc_en .. wb_en           pipeline register enables
//   de_bubble                load NOP into DE->EXE instead of DE contents
//   flush_fd, flush_de       squash FETCH->DE / DE->EXE
//   pc_sel, pc_target        redirect the PC to pc_target
//   timeout_err              sticky dmem watchdog flag
//   stall_cycles             saturating count of cycles with pc_en=0
//   flush_count              saturating count of applied redirects
// -----------------------------------------------------------------------------
module pipe_flow_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          MAX_WAIT  = 255,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             redirect_req,
  input  logic [31:0]      redirect_pc,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             ex_en,
  output logic             acc_en,
  output logic             wb_en,
  output logic             de_bubble,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // One spare bit above the 16-bit MAX_WAIT range, so "count > MAX_WAIT" is
  // still reachable when MAX_WAIT = 65535.
  localparam int WAIT_W = 17;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD_STALL,
    ST_MEM_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_pend_vld;
  logic [31:0]       r_pend_pc;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_flush_apply;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state elements take non-blocking assignments so that every flop
    // samples pre-edge values, independent of the order of the processes.
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. LOAD_STALL differs from RUN in one way only: it ignores
  // stall_req. Forwarding resolves the load-use case by that cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN, ST_LOAD_STALL: begin
        if (!dmem_ready)                      w_state_nxt = ST_MEM_WAIT;
        else if (redirect_req)                w_state_nxt = ST_RUN;
        else if (stall_req && r_state == ST_RUN) w_state_nxt = ST_LOAD_STALL;
        else                                  w_state_nxt = ST_RUN;
      end
      ST_MEM_WAIT: if (dmem_ready) w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  // Output logic. The default is full flow with nothing flushed.
  always_comb begin
    // NOTE: every output gets a default before any branch, so that no path
    // leaves a signal unassigned and infers a latch.
    pc_en         = 1'b1;
    fd_en         = 1'b1;
    de_en         = 1'b1;
    ex_en         = 1'b1;
    acc_en        = 1'b1;
    wb_en         = 1'b1;
    de_bubble     = 1'b0;
    flush_fd      = 1'b0;
    flush_de      = 1'b0;
    pc_sel        = 1'b0;
    pc_target     = '0;
    w_flush_apply = 1'b0;
    if (rst) begin
      pc_en = 1'b0;
    end else if (!dmem_ready) begin
      // The data access is still outstanding, so the whole pipeline freezes.
      // This holds in every state.
      {pc_en, fd_en, de_en, ex_en, acc_en, wb_en} = '0;
    end else begin
      case (r_state)
        ST_RUN, ST_LOAD_STALL: begin
          if (redirect_req) begin
            // Any stall_req in this cycle is dropped: its consumer is squashed.
            pc_sel        = 1'b1;
            pc_target     = redirect_pc;
            flush_fd      = 1'b1;
            flush_de      = 1'b1;
            w_flush_apply = 1'b1;
          end else if (stall_req && r_state == ST_RUN) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
          end else if (!imem_ready) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            flush_fd = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // Release cycle. A redirect resolved in this same cycle is the
          // newest one, so it takes precedence over the pending one.
          if (redirect_req || r_pend_vld) begin
            pc_sel        = 1'b1;
            pc_target     = redirect_req ? redirect_pc : r_pend_pc;
            flush_fd      = 1'b1;
            flush_de      = 1'b1;
            w_flush_apply = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pending redirect. It is captured whenever a redirect coincides with a
  // dmem wait, and a newer one overwrites it. It is consumed on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_pc  <= '0;
    end else if (!dmem_ready && redirect_req) begin
      r_pend_vld <= 1'b1;
      r_pend_pc  <= redirect_pc;
    end else if (r_state == ST_MEM_WAIT && dmem_ready) begin
      r_pend_vld <= 1'b0;
    end
  end

  // Watchdog. It counts consecutive dmem_ready=0 cycles, saturating at
  // all-ones so it cannot wrap back under MAX_WAIT.
  assign w_wait_nxt = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      timeout_err <= 1'b0;
    end else if (!dmem_ready) begin
      r_wait_cnt <= w_wait_nxt;
      if (w_wait_nxt > WAIT_W'(MAX_WAIT)) timeout_err <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Performance counters. Both saturate at all-ones. The reset cycle is not
  // counted as a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (w_flush_apply && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_flow_ctrl
//
// Directed bench for pipe_flow_ctrl, run with MAX_WAIT=8 and CNT_W=4 so that
// both the watchdog and counter saturation are reachable in a short run.
// The driver applies one input vector per cycle and pushes the hand-computed
// expected outputs for that cycle into a queue. The monitor pops the queue on
// each falling edge and compares the entry against the live DUT outputs.
// -----------------------------------------------------------------------------
module tb_pipe_flow_ctrl;

  localparam int CNT_W = 4;

  typedef struct {
    string       tag;
    logic [5:0]  en;   // {pc, fd, de, ex, acc, wb}
    logic [3:0]  fl;   // {de_bubble, flush_fd, flush_de, pc_sel}
    logic [31:0] tgt;
    logic        to;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_req, redirect_req, imem_ready, dmem_ready;
  logic [31:0]      redirect_pc;
  logic             pc_en, fd_en, de_en, ex_en, acc_en, wb_en;
  logic             de_bubble, flush_fd, flush_de, pc_sel, timeout_err;
  logic [31:0]      pc_target;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pipe_flow_ctrl #(
    .NOP_INSTR (32'h0000_0013),
    .MAX_WAIT  (8),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .redirect_req (redirect_req),
    .redirect_pc  (redirect_pc),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .de_en        (de_en),
    .ex_en        (ex_en),
    .acc_en       (acc_en),
    .wb_en        (wb_en),
    .de_bubble    (de_bubble),
    .flush_fd     (flush_fd),
    .flush_de     (flush_de),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .timeout_err  (timeout_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Applies one cycle of stimulus and queues the outputs expected in that cycle.
  task automatic cyc(input string tag, input bit r, input bit st, input bit rd,
                     input logic [31:0] rpc, input bit im, input bit dm,
                     input logic [5:0] en, input logic [3:0] fl, input logic [31:0] tgt,
                     input bit to, input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall_req = st; redirect_req = rd; redirect_pc = rpc;
    imem_ready = im; dmem_ready = dm;
    e.tag = tag; e.en = en; e.fl = fl; e.tgt = tgt; e.to = to; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  // Monitor: the controller presents a full output vector every cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.tag, ".en"}, 32'({pc_en, fd_en, de_en, ex_en, acc_en, wb_en}), 32'(e.en));
      check({e.tag, ".flush"}, 32'({de_bubble, flush_fd, flush_de, pc_sel}), 32'(e.fl));
      check({e.tag, ".target"}, pc_target, e.tgt);
      check({e.tag, ".timeout"}, 32'(timeout_err), 32'(e.to));
      check({e.tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.sc));
      check({e.tag, ".flush_count"}, 32'(flush_count), 32'(e.fc));
    end
  end

  initial begin
    rst = 1'b1; stall_req = 1'b0; redirect_req = 1'b0; redirect_pc = '0;
    imem_ready = 1'b1; dmem_ready = 1'b1;

    // Reset, then idle flow.
    for (int i = 0; i < 3; i++)
      cyc("reset", 1, 0, 0, 0, 1, 1, 6'b011111, 4'b0000, 0, 0, 0, 0);
    cyc("idle", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 0, 0);

    // A single-cycle load-use stall.
    cyc("stall", 0, 1, 0, 0, 1, 1, 6'b001111, 4'b1000, 0, 0, 0, 0);
    cyc("after_stall", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 1, 0);
    cyc("idle2", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 1, 0);

    // A redirect wins over a stall in the same cycle.
    cyc("redir_stall", 0, 1, 1, 32'h100, 1, 1, 6'b111111, 4'b0111, 32'h100, 0, 1, 0);
    cyc("post_redir", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 1, 1);

    // A redirect held across a 4-cycle dmem wait.
    cyc("mw1", 0, 0, 1, 32'h200, 1, 0, 6'b000000, 4'b0000, 0, 0, 1, 1);
    cyc("mw2", 0, 0, 0, 0, 1, 0, 6'b000000, 4'b0000, 0, 0, 2, 1);
    cyc("mw3", 0, 0, 0, 0, 1, 0, 6'b000000, 4'b0000, 0, 0, 3, 1);
    cyc("mw4", 0, 0, 0, 0, 1, 0, 6'b000000, 4'b0000, 0, 0, 4, 1);
    cyc("mw_release", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0111, 32'h200, 0, 5, 1);
    cyc("post_mw", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 5, 2);

    // A stall held for 2 cycles gives exactly 1 bubble.
    cyc("held_stall1", 0, 1, 0, 0, 1, 1, 6'b001111, 4'b1000, 0, 0, 5, 2);
    cyc("held_stall2", 0, 1, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 6, 2);
    cyc("post_held", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 6, 2);

    // An instruction-fetch miss inserts a fetch bubble.
    cyc("imem_miss", 0, 0, 0, 0, 0, 1, 6'b001111, 4'b0100, 0, 0, 6, 2);
    cyc("post_imem", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 7, 2);

    // A 10-cycle dmem wait: the watchdog trips after cycle 9, and
    // stall_cycles saturates at 15.
    for (int i = 0; i < 10; i++)
      cyc("timeout_wait", 0, 0, 0, 0, 1, 0, 6'b000000, 4'b0000, 0, (i == 9),
          4'((7 + i > 15) ? 15 : 7 + i), 2);
    cyc("to_release", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 1, 15, 2);
    cyc("to_sticky", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 1, 15, 2);

    // Synchronous reset clears the sticky flag and the counters.
    cyc("rst_mid", 1, 0, 0, 0, 1, 1, 6'b011111, 4'b0000, 0, 1, 15, 2);
    cyc("post_rst", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 0, 0);

    // Reset during a wait discards the pending redirect.
    cyc("wait_pend", 0, 0, 1, 32'h300, 1, 0, 6'b000000, 4'b0000, 0, 0, 0, 0);
    cyc("rst_in_wait", 1, 0, 0, 0, 1, 0, 6'b011111, 4'b0000, 0, 0, 1, 0);
    cyc("no_pending", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 0, 0);

    // Redirects arriving during a wait: the newest one wins.
    cyc("ow_wait1", 0, 0, 0, 0, 1, 0, 6'b000000, 4'b0000, 0, 0, 0, 0);
    cyc("ow_wait2", 0, 0, 1, 32'h400, 1, 0, 6'b000000, 4'b0000, 0, 0, 1, 0);
    cyc("ow_wait3", 0, 0, 1, 32'h500, 1, 0, 6'b000000, 4'b0000, 0, 0, 2, 0);
    cyc("ow_release", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0111, 32'h500, 0, 3, 0);
    cyc("ow_post", 0, 0, 0, 0, 1, 1, 6'b111111, 4'b0000, 0, 0, 3, 1);

    // Drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
